// File: rtl/brick_mem_ctrl_pkg.sv
// Shared constants, state encodings and the registered memory command type
// for the brick health RAM controller.
package brick_mem_ctrl_pkg;

    localparam int COORD_W  = 10;
    localparam int HEALTH_W = 2;

    localparam int                  DEF_BRICK_COLS  = 16;
    localparam int                  DEF_BRICK_ROWS  = 8;
    localparam logic [HEALTH_W-1:0] DEF_INIT_HEALTH = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT_WR   = 3'd1;
    localparam logic [2:0] ST_HIT_RD    = 3'd2;
    localparam logic [2:0] ST_HIT_WAIT  = 3'd3;
    localparam logic [2:0] ST_HIT_WR    = 3'd4;
    localparam logic [2:0] ST_DRAW_RD   = 3'd5;
    localparam logic [2:0] ST_DRAW_WAIT = 3'd6;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic                wren;
        logic [HEALTH_W-1:0] health;
    } mem_cmd_t;

    function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int cols, input int rows);
        return (int'(x) < cols) && (int'(y) < rows);
    endfunction

endpackage

// File: rtl/brick_mem_ctrl_init_counter.sv
// Row-major raster counter used to walk every brick during a level fill.
module brick_init_counter
    import brick_mem_ctrl_pkg::*;
#(
    parameter int BRICK_COLS = DEF_BRICK_COLS,
    parameter int BRICK_ROWS = DEF_BRICK_ROWS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               last
);

    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               x_wrap;

    always_comb begin
        x_wrap = (cx_q == COORD_W'(BRICK_COLS - 1));
        last   = x_wrap && (cy_q == COORD_W'(BRICK_ROWS - 1));
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (clr) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            if (x_wrap) begin
                cx_d = '0;
                cy_d = last ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx = cx_q;
    assign cy = cy_q;

endmodule

// File: rtl/brick_mem_ctrl.sv
// Arbiter/sequencer owning the single port of brick_memory: level fill,
// collision read-modify-write decrement and renderer reads.
module brick_mem_ctrl
    import brick_mem_ctrl_pkg::*;
#(
    parameter int                  BRICK_COLS  = DEF_BRICK_COLS,
    parameter int                  BRICK_ROWS  = DEF_BRICK_ROWS,
    parameter logic [HEALTH_W-1:0] INIT_HEALTH = DEF_INIT_HEALTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_start,
    output logic                init_busy,
    input  logic                hit_req,
    input  logic [COORD_W-1:0]  hit_x,
    input  logic [COORD_W-1:0]  hit_y,
    output logic                hit_ack,
    output logic                hit_was_brick,
    output logic                hit_destroyed,
    input  logic                draw_req,
    input  logic [COORD_W-1:0]  draw_x,
    input  logic [COORD_W-1:0]  draw_y,
    output logic                draw_ack,
    output logic [HEALTH_W-1:0] draw_health,
    output logic [COORD_W-1:0]  mem_x,
    output logic [COORD_W-1:0]  mem_y,
    output logic                mem_wren,
    output logic [HEALTH_W-1:0] mem_health_in,
    input  logic [HEALTH_W-1:0] mem_health
);

    logic [2:0]         state_q, state_d;
    logic               init_pend_q, init_pend_d;
    logic               init_busy_q, init_busy_d;
    mem_cmd_t           mem_q, mem_d;
    logic               was_brick_q, was_brick_d;
    logic               destroyed_q, destroyed_d;
    logic               draw_oor_q, draw_oor_d;
    logic               cnt_clr, cnt_en, cnt_last;
    logic [COORD_W-1:0] cnt_x, cnt_y;

    brick_init_counter #(
        .BRICK_COLS (BRICK_COLS),
        .BRICK_ROWS (BRICK_ROWS)
    ) u_init_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cx    (cnt_x),
        .cy    (cnt_y),
        .last  (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        init_pend_d = init_pend_q | init_start;
        // Busy covers the pending wait, the fill and the final write still on the bus.
        init_busy_d = init_start | init_pend_q | (state_q == ST_INIT_WR);
        mem_d       = mem_q;
        mem_d.wren  = 1'b0;
        was_brick_d = was_brick_q;
        destroyed_d = destroyed_q;
        draw_oor_d  = draw_oor_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (init_pend_q) begin
                    state_d     = ST_INIT_WR;
                    init_pend_d = init_start;
                    cnt_clr     = 1'b1;
                end else if (hit_req) begin
                    if (in_grid(hit_x, hit_y, BRICK_COLS, BRICK_ROWS)) begin
                        state_d = ST_HIT_RD;
                        mem_d.x = hit_x;
                        mem_d.y = hit_y;
                    end else begin
                        // Off-grid hits skip the RAM and ack straight away as a miss.
                        state_d     = ST_HIT_WR;
                        was_brick_d = 1'b0;
                        destroyed_d = 1'b0;
                    end
                end else if (draw_req) begin
                    draw_oor_d = !in_grid(draw_x, draw_y, BRICK_COLS, BRICK_ROWS);
                    if (in_grid(draw_x, draw_y, BRICK_COLS, BRICK_ROWS)) begin
                        state_d = ST_DRAW_RD;
                        mem_d.x = draw_x;
                        mem_d.y = draw_y;
                    end else begin
                        state_d = ST_DRAW_WAIT;
                    end
                end
            end
            ST_INIT_WR: begin
                mem_d.x      = cnt_x;
                mem_d.y      = cnt_y;
                mem_d.wren   = 1'b1;
                mem_d.health = INIT_HEALTH;
                cnt_en       = 1'b1;
                if (cnt_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIT_RD: begin
                state_d = ST_HIT_WAIT;
            end
            ST_HIT_WAIT: begin
                was_brick_d = (mem_health != '0);
                destroyed_d = (mem_health == HEALTH_W'(1));
                if (mem_health != '0) begin
                    mem_d.wren   = 1'b1;
                    mem_d.health = mem_health - 1'b1;
                end
                state_d = ST_HIT_WR;
            end
            ST_HIT_WR: begin
                state_d = ST_IDLE;
            end
            ST_DRAW_RD: begin
                state_d = ST_DRAW_WAIT;
            end
            ST_DRAW_WAIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            init_pend_q <= 1'b0;
            init_busy_q <= 1'b0;
            mem_q       <= '0;
            was_brick_q <= 1'b0;
            destroyed_q <= 1'b0;
            draw_oor_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pend_q <= init_pend_d;
            init_busy_q <= init_busy_d;
            mem_q       <= mem_d;
            was_brick_q <= was_brick_d;
            destroyed_q <= destroyed_d;
            draw_oor_q  <= draw_oor_d;
        end
    end

    assign init_busy     = init_busy_q;
    assign hit_ack       = (state_q == ST_HIT_WR);
    assign hit_was_brick = was_brick_q;
    assign hit_destroyed = destroyed_q;
    assign draw_ack      = (state_q == ST_DRAW_WAIT);
    assign draw_health   = (draw_ack && !draw_oor_q) ? mem_health : '0;
    assign mem_x         = mem_q.x;
    assign mem_y         = mem_q.y;
    assign mem_wren      = mem_q.wren;
    assign mem_health_in = mem_q.health;

endmodule

// File: tb/tb_brick_mem_ctrl.sv
// Randomized bench for brick_mem_ctrl with a registered-address RAM and a
// per-brick health model derived from the game rules.
module tb_brick_mem_ctrl;
    import brick_mem_ctrl_pkg::*;

    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int NB   = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_start = 1'b0;
    logic       hit_req = 1'b0, draw_req = 1'b0;
    logic [9:0] hit_x = '0, hit_y = '0, draw_x = '0, draw_y = '0;
    logic       init_busy, hit_ack, hit_was_brick, hit_destroyed, draw_ack, mem_wren;
    logic [1:0] draw_health, mem_health_in, mem_health;
    logic [9:0] mem_x, mem_y;

    brick_mem_ctrl dut (
        .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
        .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y), .hit_ack(hit_ack),
        .hit_was_brick(hit_was_brick), .hit_destroyed(hit_destroyed),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_ack(draw_ack),
        .draw_health(draw_health), .mem_x(mem_x), .mem_y(mem_y), .mem_wren(mem_wren),
        .mem_health_in(mem_health_in), .mem_health(mem_health)
    );

    always #5 clk = ~clk;

    // brick_memory stand-in: address registered, read-before-write
    typedef struct { int x; int y; int h; int cyc; } wr_t;
    bit [1:0] ram [NB];
    logic [1:0] q_r = '0;
    wr_t wlog [$];
    int cyc = 0;
    assign mem_health = q_r;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_x < 10'(COLS) && mem_y < 10'(ROWS)) begin
            q_r <= ram[int'(mem_y) * COLS + int'(mem_x)];
            if (mem_wren) ram[int'(mem_y) * COLS + int'(mem_x)] <= mem_health_in;
        end else begin
            q_r <= '0;
        end
        if (mem_wren) wlog.push_back('{int'(mem_x), int'(mem_y), int'(mem_health_in), cyc});
    end

    int hp [NB];
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic bit on_grid(input int x, input int y);
        return x < COLS && y < ROWS;
    endfunction

    task automatic run_init();
        int base, n, errs;
        base = wlog.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        chk("init_busy_rise", int'(init_busy), 1);
        n = 0;
        while (init_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_in_time", int'(n < 400), 1);
        chk("init_wr_count", wlog.size() - base, NB);
        errs = 0;
        if (wlog.size() - base >= NB) begin
            for (int i = 0; i < NB; i++) begin
                if (wlog[base+i].x != i % COLS || wlog[base+i].y != i / COLS ||
                    wlog[base+i].h != 3 || wlog[base+i].cyc != wlog[base].cyc + i) errs++;
            end
        end
        chk("init_order", errs, 0);
        for (int i = 0; i < NB; i++) hp[i] = 3;
    endtask

    task automatic do_hit(input int x, input int y, input int exp_lat);
        int k, w0, idx, h;
        idx = y * COLS + x;
        h = on_grid(x, y) ? hp[idx] : 0;
        w0 = wlog.size();
        hit_x = 10'(x); hit_y = 10'(y); hit_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1 && !hit_ack) begin
                hit_x = 10'($urandom_range(0, 1023));
                hit_y = 10'($urandom_range(0, 1023));
            end
        end while (!hit_ack && k < 400);
        hit_req = 1'b0;
        chk("hit_ack", int'(hit_ack), 1);
        if (exp_lat != 0) chk("hit_latency", k, exp_lat);
        chk("hit_was_brick", int'(hit_was_brick), int'(h != 0));
        chk("hit_destroyed", int'(hit_destroyed), int'(h == 1));
        if (h != 0) hp[idx] = h - 1;
        @(negedge clk);
        chk("hit_ack_pulse", int'(hit_ack), 0);
        chk("hit_writes", wlog.size() - w0, int'(h != 0));
        if (on_grid(x, y)) chk("hit_ram", int'(ram[idx]), hp[idx]);
    endtask

    task automatic do_draw(input int x, input int y, input int exp_lat);
        int k, w0, exp_h;
        exp_h = on_grid(x, y) ? hp[y * COLS + x] : 0;
        w0 = wlog.size();
        draw_x = 10'(x); draw_y = 10'(y); draw_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1 && !draw_ack) begin
                draw_x = 10'($urandom_range(0, 1023));
                draw_y = 10'($urandom_range(0, 1023));
            end
        end while (!draw_ack && k < 400);
        draw_req = 1'b0;
        chk("draw_ack", int'(draw_ack), 1);
        if (exp_lat != 0) chk("draw_latency", k, exp_lat);
        chk("draw_health", int'(draw_health), exp_h);
        @(negedge clk);
        chk("draw_ack_pulse", int'(draw_ack), 0);
        chk("draw_no_write", wlog.size() - w0, 0);
    endtask

    task automatic arb_test();
        int k, base, last_wr, hit_cyc, draw_cyc, wb, ds, dh;
        hit_cyc = -1; draw_cyc = -1; wb = -1; ds = -1; dh = -1; last_wr = 1 << 30;
        base = wlog.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        hit_x = 10'd7; hit_y = 10'd4; draw_x = 10'd9; draw_y = 10'd6;
        hit_req = 1'b1; draw_req = 1'b1;
        k = 0;
        while ((hit_cyc < 0 || draw_cyc < 0) && k < 400) begin
            @(negedge clk);
            k++;
            if (hit_ack) begin
                hit_cyc = cyc; wb = int'(hit_was_brick); ds = int'(hit_destroyed); hit_req = 1'b0;
            end
            if (draw_ack) begin
                draw_cyc = cyc; dh = int'(draw_health); draw_req = 1'b0;
            end
        end
        hit_req = 1'b0; draw_req = 1'b0;
        for (int i = 0; i < NB; i++) hp[i] = 3;
        chk("arb_init_writes", int'(wlog.size() - base >= NB), 1);
        if (wlog.size() - base >= NB) last_wr = wlog[base+NB-1].cyc;
        chk("arb_hit_after_init", int'(hit_cyc > last_wr), 1);
        chk("arb_draw_after_hit", int'(draw_cyc > hit_cyc), 1);
        chk("arb_hit_was_brick", wb, 1);
        chk("arb_hit_destroyed", ds, 0);
        chk("arb_draw_health", dh, hp[6 * COLS + 9]);
        hp[4 * COLS + 7] = 2;
        @(negedge clk);
    endtask

    initial begin
        int base, k, quiet, errs, x, y;
        for (int i = 0; i < NB; i++) hp[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_init_busy", int'(init_busy), 0);
        chk("rst_hit_ack", int'(hit_ack), 0);
        chk("rst_draw_ack", int'(draw_ack), 0);
        chk("rst_mem_wren", int'(mem_wren), 0);
        chk("rst_mem_xy", int'({mem_x, mem_y}), 0);
        chk("rst_health_in", int'(mem_health_in), 0);
        chk("rst_draw_health", int'(draw_health), 0);
        chk("rst_hit_flags", int'({hit_was_brick, hit_destroyed}), 0);
        reset = 1'b0;
        @(negedge clk);

        run_init();

        repeat (3) do_hit(2, 1, 3);
        repeat (4) do_hit(5, 5, 3);
        do_draw(16, 0, 1);
        do_draw(3, 8, 1);
        do_hit(16, 2, 1);
        do_hit(0, 8, 1);
        do_draw(2, 1, 2);
        do_draw(0, 0, 2);
        do_draw(15, 7, 2);

        for (int n = 0; n < 80; n++) begin
            x = $urandom_range(0, 18);
            y = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) do_hit(x, y, on_grid(x, y) ? 3 : 1);
            else do_draw(x, y, on_grid(x, y) ? 2 : 1);
        end

        // reset in the middle of a fill
        base = wlog.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        k = 0;
        while (wlog.size() - base < 40 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_init_40_writes", wlog.size() - base, 40);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wren", int'(mem_wren), 0);
        chk("mid_rst_busy", int'(init_busy), 0);
        reset = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            quiet += int'(mem_wren) + int'(hit_ack) + int'(draw_ack) + int'(init_busy);
        end
        chk("post_rst_quiet", quiet, 0);
        run_init();

        arb_test();
        do_draw(7, 4, 2);

        errs = 0;
        for (int i = 0; i < NB; i++) if (int'(ram[i]) != hp[i]) errs++;
        chk("final_ram", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
